// File: rtl/mips_pkg.sv
// Shared pipeline types and widths for the MIPS memory stage.
`timescale 1ns/1ps
package mips_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_BITS   = 5;

    typedef enum logic {IDLE, WAIT} memstate_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory stage; flags when an access has waited LIMIT cycles.
// Only instantiated when MEM_STAGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mem_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = active && (count == CW'(LIMIT));

    // Held at zero outside WAIT, so every new wait starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (!active)
            count <= '0;
        else if (!expired)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS M stage: data-memory req/ack handshake, stall generation, M/W register, stall counter.
// Optional bus-timeout abort is enabled by defining MEM_STAGE_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH   = WORD_WIDTH,
    parameter int REGBITS = REG_BITS
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               validM,
    input  logic               memtoregM,
    input  logic               memwriteM,
    input  logic               regwriteM,
    input  logic [WIDTH-1:0]   aluoutM,
    input  logic [WIDTH-1:0]   writedataM,
    input  logic [REGBITS-1:0] writeregM,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               stallM,
    output logic [WIDTH-1:0]   readdataW,
    output logic [WIDTH-1:0]   aluoutW,
    output logic [REGBITS-1:0] writeregW,
    output logic               regwriteW,
    output logic               memtoregW,
    output logic               bus_errW,
    output logic [31:0]        stall_count
);

    memstate_t state, state_next;
    logic      access;
    logic      timeout;

    assign access = validM & (memtoregM | memwriteM);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        unique case (state)
            IDLE: begin
                mem_req = access;
                if (access && !mem_ack)
                    state_next = WAIT;
            end
            WAIT: begin
                if (timeout) begin
                    state_next = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // The request must fall the moment reset asserts, not at the next edge.
        if (!reset)
            mem_req = 1'b0;
    end

    assign mem_we    = memwriteM & mem_req;
    assign mem_addr  = {aluoutM[WIDTH-1:2], 2'b00};
    assign mem_wdata = writedataM;
    assign stallM    = mem_req & ~mem_ack;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .active (state == WAIT),
        .expired(timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_errW <= 1'b0;
        else
            bus_errW <= timeout;
    end
`else
    assign timeout  = 1'b0;
    assign bus_errW = 1'b0;
`endif

    // M/W register: a stalled or aborted access forwards a bubble; data fields hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdataW <= '0;
            aluoutW   <= '0;
            writeregW <= '0;
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else if (stallM || timeout) begin
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else begin
            aluoutW   <= aluoutM;
            writeregW <= writeregM;
            regwriteW <= regwriteM & validM;
            memtoregW <= memtoregM & validM;
            if (memtoregM)
                readdataW <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stallM && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

endmodule
